// File: rtl/bin2bcd_iter_if.sv
// Handshake bundle for the iterative binary-to-BCD converter.
// Carries the start strobe, the operand, the packed BCD result and the done/ready status.
// master drives ena/hex; slave (the converter) drives dec/ena_o/ovf/ready.
interface bin2bcd_iter_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic                  ena;
    logic [DATA_W-1:0]     hex;
    logic [4*DIGITS-1:0]   dec;
    logic                  ena_o;
    logic                  ovf;
    logic                  ready;

    modport master (
        output ena,
        output hex,
        input  dec,
        input  ena_o,
        input  ovf,
        input  ready
    );

    modport slave (
        input  ena,
        input  hex,
        output dec,
        output ena_o,
        output ovf,
        output ready
    );
endinterface

// File: rtl/bin2bcd_iter.sv
// Sequential double-dabble binary-to-BCD converter with saturating overflow.
// Latency: DATA_W cycles from the accepting edge to the ena_o strobe.
// Backpressure: ready is low while shifting; ena is ignored (not queued) then.
module bin2bcd_iter #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_iter_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [BCD_W-1:0] SAT_VAL = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [BCD_W-1:0]  dec_q, dec_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [BCD_W-1:0]  acc_adj;
    logic [BCD_W-1:0]  acc_sh;
    logic [DATA_W-1:0] sr_sh;
    logic              carry_out;
    logic              sticky_nxt;

    // Per-digit correction: any digit >= 5 gets +3 so the following doubling
    // carries correctly into the next digit. Digits never carry into each other here.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // One-bit left shift of {accumulator, operand}; the bit leaving the top digit
    // means the running value has reached 10^DIGITS.
    assign {carry_out, acc_sh, sr_sh} = {acc_adj, sr_q, 1'b0};
    assign sticky_nxt = sticky_q | carry_out;

    // Next-state and datapath control; ready is derived from the state register alone.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dec_d    = dec_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.ena) begin
                    sr_d     = bus.hex;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(DATA_W);
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_d     = sr_sh;
                acc_d    = acc_sh;
                sticky_d = sticky_nxt;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Final shift: publish the result, saturated to all nines on overflow.
                    state_d = ST_DONE;
                    dec_d   = sticky_nxt ? SAT_VAL : acc_sh;
                    ovf_d   = sticky_nxt;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            dec_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dec_q    <= dec_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.dec   = dec_q;
    assign bus.ovf   = ovf_q;
    assign bus.ena_o = done_q;
    assign bus.ready = (state_q != ST_SHIFT);

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed bench for bin2bcd_iter across four parameter sets.
module tb_bin2bcd_iter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bin2bcd_iter_if #(.DATA_W(8),  .DIGITS(3)) if0 ();
    bin2bcd_iter_if #(.DATA_W(8),  .DIGITS(2)) if1 ();
    bin2bcd_iter_if #(.DATA_W(16), .DIGITS(5)) if2 ();
    bin2bcd_iter_if #(.DATA_W(1),  .DIGITS(1)) if3 ();

    bin2bcd_iter #(.DATA_W(8),  .DIGITS(3)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    bin2bcd_iter #(.DATA_W(8),  .DIGITS(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    bin2bcd_iter #(.DATA_W(16), .DIGITS(5)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    bin2bcd_iter #(.DATA_W(1),  .DIGITS(1)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic done_of(input int s);
        case (s)
            0:       return if0.ena_o;
            1:       return if1.ena_o;
            2:       return if2.ena_o;
            default: return if3.ena_o;
        endcase
    endfunction

    task automatic drive(input int s, input logic e, input logic [15:0] h);
        case (s)
            0:       begin if0.ena = e; if0.hex = h[7:0]; end
            1:       begin if1.ena = e; if1.hex = h[7:0]; end
            2:       begin if2.ena = e; if2.hex = h;      end
            default: begin if3.ena = e; if3.hex = h[0];   end
        endcase
    endtask

    // Pulse ena for one edge from a negedge; returns at the negedge after acceptance.
    task automatic start(input int s, input logic [15:0] h);
        drive(s, 1'b1, h);
        @(negedge clk);
        drive(s, 1'b0, 16'd0);
    endtask

    // Counts edges after the accepting edge until ena_o is seen; -1 on timeout.
    task automatic wait_done(input int s, input int budget, output int n);
        n = 0;
        while (!done_of(s)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (if0.dec !== 12'h000) begin errors++; $display("FAIL reset_dec got %h want 000", if0.dec); end
        checks++; if (if0.ena_o !== 1'b0) begin errors++; $display("FAIL reset_ena_o got %b want 0", if0.ena_o); end
        checks++; if (if0.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", if0.ovf); end
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if0.ready); end
        checks++; if (if2.dec !== 20'h00000) begin errors++; $display("FAIL reset_dec_wide got %h want 00000", if2.dec); end
    endtask

    task automatic test_max_value();
        int n;
        start(0, 16'd255);
        wait_done(0, 20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL max_latency got %0d want 8", n); end
        checks++; if (if0.dec !== 12'h255) begin errors++; $display("FAIL max_dec got %h want 255", if0.dec); end
        checks++; if (if0.ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got %b want 0", if0.ovf); end
        @(negedge clk);
        checks++; if (if0.ena_o !== 1'b0) begin errors++; $display("FAIL max_strobe_width got %b want 0", if0.ena_o); end
        repeat (10) @(negedge clk);
        checks++; if (if0.dec !== 12'h255) begin errors++; $display("FAIL max_hold got %h want 255", if0.dec); end
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL max_idle_ready got %b want 1", if0.ready); end
    endtask

    task automatic test_back_to_back();
        int n;
        start(0, 16'd30);
        wait_done(0, 20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", n); end
        checks++; if (if0.dec !== 12'h030) begin errors++; $display("FAIL b2b_first_dec got %h want 030", if0.dec); end
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got %b want 1", if0.ready); end
        start(0, 16'd0);
        checks++; if (if0.ready !== 1'b0) begin errors++; $display("FAIL b2b_no_idle got %b want 0", if0.ready); end
        checks++; if (if0.ena_o !== 1'b0) begin errors++; $display("FAIL b2b_strobe_fall got %b want 0", if0.ena_o); end
        wait_done(0, 20, n);
        checks++; if (n + 1 !== 9) begin errors++; $display("FAIL b2b_spacing got %0d want 9", n + 1); end
        checks++; if (if0.dec !== 12'h000) begin errors++; $display("FAIL b2b_second_dec got %h want 000", if0.dec); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int pulses;
        int first;
        int rdy_bad;
        pulses  = 0;
        first   = 0;
        rdy_bad = 0;
        start(0, 16'd42);
        for (int k = 1; k <= 20; k++) begin
            if (k >= 2 && k <= 8 && if0.ready !== 1'b0) rdy_bad++;
            if (if0.ena_o === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 3) drive(0, 1'b1, 16'd99);
            if (k == 4) drive(0, 1'b0, 16'd0);
            @(negedge clk);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses got %0d want 1", pulses); end
        checks++; if (first !== 9) begin errors++; $display("FAIL busy_latency got %0d want 9", first); end
        checks++; if (if0.dec !== 12'h042) begin errors++; $display("FAIL busy_dec got %h want 042", if0.dec); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL busy_ready got %0d bad cycles want 0", rdy_bad); end
    endtask

    task automatic test_overflow();
        int n;
        start(1, 16'd100);
        wait_done(1, 20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL ovf_latency got %0d want 8", n); end
        checks++; if (if1.dec !== 8'h99) begin errors++; $display("FAIL ovf_sat_dec got %h want 99", if1.dec); end
        checks++; if (if1.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", if1.ovf); end
        @(negedge clk);
        start(1, 16'd99);
        wait_done(1, 20, n);
        checks++; if (if1.dec !== 8'h99) begin errors++; $display("FAIL ovf_edge_dec got %h want 99", if1.dec); end
        checks++; if (if1.ovf !== 1'b0) begin errors++; $display("FAIL ovf_edge_flag got %b want 0", if1.ovf); end
        @(negedge clk);
        start(1, 16'd255);
        wait_done(1, 20, n);
        checks++; if (if1.dec !== 8'h99 || if1.ovf !== 1'b1) begin errors++; $display("FAIL ovf_255 got %h/%b want 99/1", if1.dec, if1.ovf); end
        @(negedge clk);
    endtask

    task automatic test_wide();
        int n;
        start(2, 16'hFFFF);
        wait_done(2, 40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL wide_latency got %0d want 16", n); end
        checks++; if (if2.dec !== 20'h65535) begin errors++; $display("FAIL wide_dec got %h want 65535", if2.dec); end
        checks++; if (if2.ovf !== 1'b0) begin errors++; $display("FAIL wide_ovf got %b want 0", if2.ovf); end
        @(negedge clk);
        start(2, 16'd1234);
        wait_done(2, 40, n);
        checks++; if (if2.dec !== 20'h01234) begin errors++; $display("FAIL wide_mid_dec got %h want 01234", if2.dec); end
        @(negedge clk);
    endtask

    task automatic test_single_bit();
        int n;
        start(3, 16'd1);
        wait_done(3, 10, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL w1_latency got %0d want 1", n); end
        checks++; if (if3.dec !== 4'h1) begin errors++; $display("FAIL w1_dec got %h want 1", if3.dec); end
        @(negedge clk);
        checks++; if (if3.ready !== 1'b1 || if3.ena_o !== 1'b0) begin errors++; $display("FAIL w1_idle got rdy %b ena_o %b want 1/0", if3.ready, if3.ena_o); end
    endtask

    task automatic test_reset_abort();
        int n;
        int pulses;
        pulses = 0;
        start(0, 16'd200);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (if0.dec !== 12'h000) begin errors++; $display("FAIL abort_dec got %h want 000", if0.dec); end
        checks++; if (if0.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", if0.ready); end
        for (int k = 0; k < 12; k++) begin
            if (if0.ena_o === 1'b1) pulses++;
            if (k == 2) rst = 1'b1;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_strobe got %0d pulses want 0", pulses); end
        start(0, 16'd7);
        wait_done(0, 20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL abort_restart_latency got %0d want 8", n); end
        checks++; if (if0.dec !== 12'h007) begin errors++; $display("FAIL abort_restart_dec got %h want 007", if0.dec); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(0, 1'b0, 16'd0);
        drive(1, 1'b0, 16'd0);
        drive(2, 1'b0, 16'd0);
        drive(3, 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_max_value();
        test_back_to_back();
        test_ignore_busy();
        test_overflow();
        test_wide();
        test_single_bit();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
